// File: rtl/serial_adder_if.sv
// Handshake bundle for the bit-serial adder: operand channel in, result channel out.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    // Producer/consumer side of the adder
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    // The adder itself
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, carry held in a flop,
// operands shifted out LSB-first, sum shifted in MSB-first, result offered
// through a valid/ready handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_cout;

    // Single full-adder slice on the current LSBs and the held carry
    always_comb begin
        fa_sum  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_cout = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = RUN;
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    sum_sh_d = '0;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // Concatenate-then-shift keeps this legal for WIDTH == 1
                sum_sh_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
                carry_d  = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    // Handshake flags are pure state decodes; result comes straight from flops
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_sh_q;
    assign bus.cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 8, 1 and 16.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(1))  if1  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    int n_checks = 0;
    int n_pass   = 0;

    // Drive one WIDTH=8 operation; returns result at the first DONE negedge.
    // lat counts edges after the accept edge until out_valid is visible.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic rdy, output logic [7:0] s, output logic co,
                        output int lat, output int bcnt, output logic ok);
        @(negedge clk);
        if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1; if8.out_ready = rdy;
        for (int i = 0; i < 20; i++) begin
            if (if8.in_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0;
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if8.out_valid) begin
                ok = 1'b1;
                break;
            end
            if (if8.busy) bcnt++;
            lat++;
            @(negedge clk);
        end
        s = if8.sum; co = if8.cout;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset8: rdy/vld/busy/sum/cout=%b/%b/%b/%h/%b required 1/0/0/00/0",
                     if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout);
        else n_pass++;
        n_checks++;
        if ({if1.in_ready, if1.out_valid, if16.in_ready, if16.out_valid, if16.sum} !== {1'b1, 1'b0, 1'b1, 1'b0, 16'h0})
            $display("FAIL reset1_16: w1 rdy/vld=%b/%b w16 rdy/vld/sum=%b/%b/%h required 1/0 1/0/0000",
                     if1.in_ready, if1.out_valid, if16.in_ready, if16.out_valid, if16.sum);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; int lat, bcnt; logic ok;
        run8(8'h5A, 8'h3C, 1'b0, 1'b1, s, co, lat, bcnt, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_timeout: out_valid never rose");
        else n_pass++;
        n_checks++;
        if ({co, s} !== 9'h096) $display("FAIL basic_sum: got %b/%h required 0/96", co, s);
        else n_pass++;
        n_checks++;
        if (lat + 1 !== 9) $display("FAIL basic_latency: out_valid at edge +%0d required +9", lat + 1);
        else n_pass++;
        n_checks++;
        if (bcnt !== 8) $display("FAIL basic_busy: busy for %0d cycles required 8", bcnt);
        else n_pass++;
    endtask

    task automatic test_carry();
        logic [7:0] s; logic co; int lat, bcnt; logic ok;
        logic [7:0] va [5] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 8'hAA};
        logic [7:0] vb [5] = '{8'h01, 8'hFF, 8'h00, 8'h80, 8'h55};
        logic       vc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [8:0] ve [5] = '{9'h100, 9'h1FF, 9'h001, 9'h100, 9'h100};
        for (int i = 0; i < 5; i++) begin
            run8(va[i], vb[i], vc[i], 1'b1, s, co, lat, bcnt, ok);
            n_checks++;
            if (ok !== 1'b1 || {co, s} !== ve[i])
                $display("FAIL carry_%0d: got ok=%b %b/%h required %b/%h", i, ok, co, s, ve[i][8], ve[i][7:0]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic co; int lat, bcnt; logic ok;
        run8(8'h3E, 8'h47, 1'b1, 1'b0, s, co, lat, bcnt, ok);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({if8.out_valid, if8.in_ready, if8.cout, if8.sum} !== {1'b1, 1'b0, 1'b0, 8'h86})
                $display("FAIL hold_%0d: vld/rdy/cout/sum=%b/%b/%b/%h required 1/0/0/86",
                         i, if8.out_valid, if8.in_ready, if8.cout, if8.sum);
            else n_pass++;
        end
        @(negedge clk);
        if8.out_ready = 1'b1;
        n_checks++;
        if (if8.out_valid !== 1'b1) $display("FAIL hold_6th: out_valid=%b required 1", if8.out_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({if8.in_ready, if8.out_valid} !== 2'b10)
            $display("FAIL retire: rdy/vld=%b/%b required 1/0", if8.in_ready, if8.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s; logic co; int lat, bcnt; logic ok;
        @(negedge clk);
        if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b0; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0})
            $display("FAIL midrun_reset: rdy/vld/busy/sum/cout=%b/%b/%b/%h/%b required 1/0/0/00/0",
                     if8.in_ready, if8.out_valid, if8.busy, if8.sum, if8.cout);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (if8.out_valid) ok = 1'b1;
        end
        n_checks++;
        if (ok !== 1'b0) $display("FAIL midrun_no_valid: out_valid=1 after reset required 0");
        else n_pass++;
        run8(8'h01, 8'h01, 1'b0, 1'b1, s, co, lat, bcnt, ok);
        n_checks++;
        if (ok !== 1'b1 || {co, s} !== 9'h002)
            $display("FAIL after_reset: got ok=%b %b/%h required 0/02", ok, co, s);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic ok;
        @(negedge clk);
        if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b1; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Other operands kept valid throughout RUN and DONE must not be captured
        if8.a = 8'hFF; if8.b = 8'hFF;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if8.out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b1 || {if8.cout, if8.sum, if8.in_ready} !== {9'h047, 1'b0})
            $display("FAIL ignore_inval: ok=%b cout/sum/rdy=%b/%h/%b required 0/47/0",
                     ok, if8.cout, if8.sum, if8.in_ready);
        else n_pass++;
        if8.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({if8.in_ready, if8.out_valid, if8.busy} !== 3'b100)
            $display("FAIL retire_no_accept: rdy/vld/busy=%b/%b/%b required 1/0/0",
                     if8.in_ready, if8.out_valid, if8.busy);
        else n_pass++;
        @(negedge clk);
        if8.in_valid = 1'b0;
        n_checks++;
        if (if8.busy !== 1'b1) $display("FAIL next_accept: busy=%b required 1", if8.busy);
        else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (if8.out_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (ok !== 1'b1 || {if8.cout, if8.sum} !== 9'h1FF)
            $display("FAIL next_result: ok=%b got %b/%h required 1/ff", ok, if8.cout, if8.sum);
        else n_pass++;
    endtask

    task automatic test_random_w1();
        logic a, b, c; logic [1:0] exp_v; int lat; logic ok;
        int bad_lat = 0;
        if1.out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            exp_v = 2'(a) + 2'(b) + 2'(c);
            if1.a = a; if1.b = b; if1.cin = c; if1.in_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (if1.in_ready) break;
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            if1.in_valid = 1'b0;
            ok = 1'b0; lat = 0;
            for (int i = 0; i < 10; i++) begin
                if (if1.out_valid) begin ok = 1'b1; break; end
                lat++;
                @(negedge clk);
            end
            if (lat + 1 != 2) bad_lat++;
            n_checks++;
            if (ok !== 1'b1 || {if1.cout, if1.sum} !== exp_v)
                $display("FAIL w1_op%0d: %b+%b+%b ok=%b got %b%b required %b", n, a, b, c, ok, if1.cout, if1.sum, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (bad_lat !== 0) $display("FAIL w1_latency: %0d ops not at 2 edges, required 0", bad_lat);
        else n_pass++;
    endtask

    task automatic test_random_w16();
        logic [15:0] a, b; logic c; logic [16:0] exp_v; logic ok;
        if16.out_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
            exp_v = 17'(a) + 17'(b) + 17'(c);
            if16.a = a; if16.b = b; if16.cin = c; if16.in_valid = 1'b1;
            for (int i = 0; i < 10; i++) begin
                if (if16.in_ready) break;
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            if16.in_valid = 1'b0;
            ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (if16.out_valid) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            n_checks++;
            if (ok !== 1'b1 || {if16.cout, if16.sum} !== exp_v)
                $display("FAIL w16_op%0d: %h+%h+%b ok=%b got %b/%h required %h", n, a, b, c, ok, if16.cout, if16.sum, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;  if8.out_ready = 1'b0;
        if1.in_valid = 1'b0;  if1.a = '0;  if1.b = '0;  if1.cin = 1'b0;  if1.out_ready = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random_w1();
        test_random_w16();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
